// File: rtl/irq_pkg.sv
// Shared definitions for the vectored, nesting interrupt controller:
// default configuration, EPC stack entry layout and index-width helper.
package irq_pkg;

    localparam int          N_IRQ_DEF      = 3;
    localparam int          WIDTH_DEF      = 32;
    localparam int          NEST_DEPTH_DEF = 2;
    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0080;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

    // Channel field is wide enough for up to 256 sources.
    localparam int CHAN_W = 8;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] pc;
        logic [CHAN_W-1:0]    chan;
    } stack_ent_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Core-side connection of the interrupt controller: request lines, commit/PC
// path, mask/enable writes and the controller status outputs.
interface irq_ctrl_if #(
    parameter int N_IRQ      = irq_pkg::N_IRQ_DEF,
    parameter int WIDTH      = irq_pkg::WIDTH_DEF,
    parameter int NEST_DEPTH = irq_pkg::NEST_DEPTH_DEF
);
    localparam int DW = $clog2(NEST_DEPTH + 1);

    logic [N_IRQ-1:0] irq;
    logic             commit_en;
    logic [WIDTH-1:0] pc_next;
    logic             eret;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             ie_we;
    logic             ie_wdata;

    logic             redirect;
    logic [WIDTH-1:0] pc_target;
    logic [WIDTH-1:0] epc;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] in_service;
    logic [DW-1:0]    depth;
    logic             eret_err;

    modport master (
        output irq, commit_en, pc_next, eret, mask_we, mask_wdata, ie_we, ie_wdata,
        input  redirect, pc_target, epc, pending, in_service, depth, eret_err
    );

    modport slave (
        input  irq, commit_en, pc_next, eret, mask_we, mask_wdata, ie_we, ie_wdata,
        output redirect, pc_target, epc, pending, in_service, depth, eret_err
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Priority encoder: reports whether any request is set and the index of the
// highest set bit.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller with strict-priority nesting: latches request
// edges, redirects the PC to channel entrances and unwinds via an EPC stack.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int              N_IRQ      = N_IRQ_DEF,
    parameter int              WIDTH      = WIDTH_DEF,
    parameter int              NEST_DEPTH = NEST_DEPTH_DEF,
    parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(VEC_BASE_DEF),
    parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(VEC_STRIDE_DEF)
) (
    input  logic       clk,
    input  logic       rst_n,
    irq_ctrl_if.slave  bus
);

    localparam int IW = idx_w(N_IRQ);
    localparam int SW = idx_w(NEST_DEPTH);
    localparam int DW = $clog2(NEST_DEPTH + 1);

    logic [N_IRQ-1:0] irq_q, pending, pending_nxt, in_service, mask;
    logic [N_IRQ-1:0] edges, eligible;
    logic             ie, eret_err, take, ret, k_valid;
    logic [IW-1:0]    k;
    logic [DW-1:0]    depth;
    logic [SW-1:0]    top_idx, push_idx;
    logic [WIDTH-1:0] vec_pc;
    stack_ent_t       stack [NEST_DEPTH];
    stack_ent_t       top_ent;

    assign edges    = bus.irq & ~irq_q;
    assign eligible = pending & ~mask;
    assign top_idx  = SW'(depth - DW'(1));
    assign push_idx = SW'(depth);
    assign top_ent  = stack[top_idx];

    irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_prio_enc (
        .req   (eligible),
        .valid (k_valid),
        .idx   (k)
    );

    // Only a strictly higher channel may preempt the one in service.
    always_comb begin
        take = ie & bus.commit_en & ~bus.eret & k_valid
             & (depth < DW'(NEST_DEPTH))
             & ((depth == '0) | (CHAN_W'(k) > top_ent.chan));
    end

    assign ret    = bus.commit_en & bus.eret & (depth != '0);
    assign vec_pc = VEC_BASE + WIDTH'(k) * VEC_STRIDE;

    always_comb begin
        bus.pc_target = bus.pc_next;
        if (!rst_n)
            bus.pc_target = '0;
        else if (ret)
            bus.pc_target = WIDTH'(top_ent.pc);
        else if (take)
            bus.pc_target = vec_pc;
    end

    // A fresh edge on the channel being taken keeps it pending.
    always_comb begin
        pending_nxt = pending;
        if (take)
            pending_nxt[k] = 1'b0;
        pending_nxt = pending_nxt | edges;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q      <= '0;
            pending    <= '0;
            in_service <= '0;
            mask       <= '0;
            ie         <= 1'b0;
            eret_err   <= 1'b0;
            depth      <= '0;
            for (int i = 0; i < NEST_DEPTH; i++)
                stack[i] <= '0;
        end else begin
            irq_q   <= bus.irq;
            pending <= pending_nxt;
            if (bus.mask_we)
                mask <= bus.mask_wdata;
            if (bus.ie_we)
                ie <= bus.ie_wdata;
            if (bus.commit_en && bus.eret && (depth == '0))
                eret_err <= 1'b1;
            if (take) begin
                stack[push_idx] <= '{pc: WIDTH_DEF'(bus.pc_next), chan: CHAN_W'(k)};
                in_service[k]   <= 1'b1;
                depth           <= depth + DW'(1);
            end else if (ret) begin
                stack[top_idx] <= '0;
                in_service     <= in_service & ~(N_IRQ'(1) << top_ent.chan);
                depth          <= depth - DW'(1);
            end
        end
    end

    assign bus.redirect   = take | ret;
    assign bus.epc        = (depth != '0) ? WIDTH'(top_ent.pc) : '0;
    assign bus.pending    = pending;
    assign bus.in_service = in_service;
    assign bus.depth      = depth;
    assign bus.eret_err   = eret_err;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios followed by random traffic, all
// compared against a queue-based reference model of the controller.
module tb_irq_ctrl;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    logic        obs_redir;
    logic [31:0] obs_tgt;

    typedef struct {
        logic [31:0] pc;
        int          chan;
    } ent_t;

    ent_t        stk[$];
    logic [2:0]  m_pend, m_mask, m_irq_q;
    logic        m_ie, m_err, m_take, m_ret;
    int          m_k;
    logic [31:0] m_tgt;

    irq_ctrl_if #(.N_IRQ(3), .WIDTH(32), .NEST_DEPTH(2)) bus ();

    irq_ctrl #(
        .N_IRQ(3), .WIDTH(32), .NEST_DEPTH(2),
        .VEC_BASE(32'h80), .VEC_STRIDE(32'h10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] m_insvc();
        logic [2:0] v;
        v = '0;
        foreach (stk[i]) v[stk[i].chan] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        stk.delete();
        m_pend  = '0;
        m_mask  = '0;
        m_irq_q = '0;
        m_ie    = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_comb();
        logic [2:0] elig;
        int cur;
        elig = m_pend & ~m_mask;
        cur  = (stk.size() > 0) ? stk[$].chan : -1;
        m_k  = -1;
        for (int i = 0; i < N; i++)
            if (elig[i]) m_k = i;
        m_take = m_ie && bus.commit_en && !bus.eret && (m_k >= 0)
              && (stk.size() < 2) && (m_k > cur);
        m_ret  = bus.commit_en && bus.eret && (stk.size() > 0);
        if (m_ret)       m_tgt = stk[$].pc;
        else if (m_take) m_tgt = 32'h80 + 32'(m_k) * 32'h10;
        else             m_tgt = bus.pc_next;
    endtask

    task automatic model_edge();
        logic [2:0] edges;
        ent_t e;
        edges = bus.irq & ~m_irq_q;
        if (m_ret) begin
            void'(stk.pop_back());
        end else if (m_take) begin
            e.pc   = bus.pc_next;
            e.chan = m_k;
            stk.push_back(e);
            m_pend[m_k] = 1'b0;
        end
        if (bus.commit_en && bus.eret && !m_ret) m_err = 1'b1;
        m_pend = m_pend | edges;
        if (bus.mask_we) m_mask = bus.mask_wdata;
        if (bus.ie_we)   m_ie   = bus.ie_wdata;
        m_irq_q = bus.irq;
    endtask

    task automatic check_state();
        chk("pending",    32'(bus.pending),    32'(m_pend));
        chk("in_service", 32'(bus.in_service), 32'(m_insvc()));
        chk("depth",      32'(bus.depth),      32'(stk.size()));
        chk("epc",        bus.epc,             (stk.size() > 0) ? stk[$].pc : 32'h0);
        chk("eret_err",   32'(bus.eret_err),   32'(m_err));
    endtask

    task automatic cycle();
        @(negedge clk);
        model_comb();
        obs_redir = bus.redirect;
        obs_tgt   = bus.pc_target;
        chk("redirect",  32'(obs_redir), 32'(m_take | m_ret));
        chk("pc_target", obs_tgt, m_tgt);
        @(posedge clk);
        #1;
        model_edge();
        check_state();
    endtask

    task automatic drive(input logic [2:0] irq, input logic commit, input logic eret,
                         input logic [31:0] pc);
        bus.irq        = irq;
        bus.commit_en  = commit;
        bus.eret       = eret;
        bus.pc_next    = pc;
        bus.mask_we    = 1'b0;
        bus.ie_we      = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.irq        = '0;
        bus.commit_en  = 1'b1;
        bus.pc_next    = 32'h40;
        bus.eret       = 1'b0;
        bus.mask_we    = 1'b0;
        bus.mask_wdata = '0;
        bus.ie_we      = 1'b0;
        bus.ie_wdata   = 1'b0;
        model_reset();

        // Reset and idle
        #3;
        chk("rst_redirect",   32'(bus.redirect),   32'h0);
        chk("rst_pc_target",  bus.pc_target,       32'h0);
        chk("rst_epc",        bus.epc,             32'h0);
        chk("rst_pending",    32'(bus.pending),    32'h0);
        chk("rst_in_service", 32'(bus.in_service), 32'h0);
        chk("rst_depth",      32'(bus.depth),      32'h0);
        chk("rst_eret_err",   32'(bus.eret_err),   32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        drive(3'b001, 1, 0, 32'h40); cycle();
        chk("t1_redirect", 32'(obs_redir), 32'h0);
        chk("t1_target",   obs_tgt, 32'h40);
        drive(3'b000, 1, 0, 32'h40); cycle();
        chk("t1_no_take",  32'(obs_redir), 32'h0);
        chk("t1_pending",  32'(bus.pending), 32'h1);

        // Basic take and return
        drive(3'b001, 1, 0, 32'h100);
        bus.ie_we = 1'b1; bus.ie_wdata = 1'b1;
        bus.mask_we = 1'b1; bus.mask_wdata = 3'b000;
        cycle();
        chk("t2_old_ie", 32'(obs_redir), 32'h0);
        drive(3'b000, 1, 0, 32'h100); cycle();
        chk("t2_take_tgt", obs_tgt, 32'h80);
        chk("t2_epc",      bus.epc, 32'h100);
        chk("t2_insvc",    32'(bus.in_service), 32'h1);
        chk("t2_pending",  32'(bus.pending), 32'h0);
        drive(3'b000, 1, 1, 32'h104); cycle();
        chk("t2_ret_tgt",  obs_tgt, 32'h100);
        chk("t2_depth0",   32'(bus.depth), 32'h0);

        // Simultaneous requests
        drive(3'b101, 1, 0, 32'h180); cycle();
        drive(3'b000, 1, 0, 32'h200); cycle();
        chk("t3_take2",    obs_tgt, 32'hA0);
        chk("t3_pend0",    32'(bus.pending), 32'h1);
        drive(3'b000, 1, 0, 32'h204); cycle();
        chk("t3_below",    32'(obs_redir), 32'h0);
        drive(3'b000, 1, 1, 32'h208); cycle();
        chk("t3_ret",      obs_tgt, 32'h200);
        drive(3'b000, 1, 0, 32'h300); cycle();
        chk("t3_take0",    obs_tgt, 32'h80);
        drive(3'b000, 1, 1, 32'h304); cycle();

        // Nesting and limits
        drive(3'b010, 1, 0, 32'h1F0); cycle();
        drive(3'b000, 1, 0, 32'h200); cycle();
        chk("t4_take1",    obs_tgt, 32'h90);
        drive(3'b100, 1, 0, 32'h2F0); cycle();
        drive(3'b001, 1, 0, 32'h300); cycle();
        chk("t4_preempt",  obs_tgt, 32'hA0);
        chk("t4_depth2",   32'(bus.depth), 32'h2);
        drive(3'b000, 1, 0, 32'h304); cycle();
        chk("t4_full",     32'(obs_redir), 32'h0);
        chk("t4_pend0",    32'(bus.pending), 32'h1);
        drive(3'b000, 1, 1, 32'h308); cycle();
        chk("t4_ret1",     obs_tgt, 32'h300);
        drive(3'b000, 1, 1, 32'h30C); cycle();
        chk("t4_ret2",     obs_tgt, 32'h200);
        drive(3'b000, 1, 0, 32'h200); cycle();
        drive(3'b000, 1, 1, 32'h204); cycle();

        // Boundaries
        drive(3'b000, 1, 1, 32'h208); cycle();
        chk("t5_eret0_redir", 32'(obs_redir), 32'h0);
        chk("t5_eret_err",    32'(bus.eret_err), 32'h1);
        drive(3'b010, 1, 0, 32'h210);
        bus.mask_we = 1'b1; bus.mask_wdata = 3'b010;
        cycle();
        repeat (3) begin
            drive(3'b000, 1, 0, 32'h214); cycle();
            chk("t5_masked", 32'(obs_redir), 32'h0);
        end
        chk("t5_mask_pend", 32'(bus.pending), 32'h2);
        drive(3'b000, 0, 0, 32'h220);
        bus.mask_we = 1'b1; bus.mask_wdata = 3'b000;
        cycle();
        drive(3'b000, 0, 0, 32'h224); cycle();
        chk("t5_nocommit", 32'(obs_redir), 32'h0);
        drive(3'b000, 1, 0, 32'h230); cycle();
        chk("t5_commit",   obs_tgt, 32'h90);
        drive(3'b100, 1, 0, 32'h240); cycle();
        drive(3'b000, 1, 1, 32'h244); cycle();
        chk("t5_eret_wins", obs_tgt, 32'h230);
        chk("t5_kept",      32'(bus.pending), 32'h4);
        drive(3'b000, 1, 0, 32'h250); cycle();
        chk("t5_after",     obs_tgt, 32'hA0);

        // Reset mid-service
        drive(3'b000, 1, 1, 32'h254); cycle();
        drive(3'b010, 1, 0, 32'h260); cycle();
        drive(3'b100, 1, 0, 32'h270); cycle();
        drive(3'b000, 1, 0, 32'h280); cycle();
        chk("t6_depth2", 32'(bus.depth), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_depth",  32'(bus.depth), 32'h0);
        chk("t6_insvc",  32'(bus.in_service), 32'h0);
        chk("t6_epc",    bus.epc, 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
        drive(3'b000, 1, 1, 32'h290); cycle();
        chk("t6_no_redir", 32'(obs_redir), 32'h0);

        // Random traffic
        drive(3'b000, 1, 0, 32'h400);
        bus.ie_we = 1'b1; bus.ie_wdata = 1'b1;
        cycle();
        repeat (400) begin
            drive(3'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 4) == 0), $urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 15) == 0) begin
                bus.mask_we    = 1'b1;
                bus.mask_wdata = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 31) == 0) begin
                bus.ie_we    = 1'b1;
                bus.ie_wdata = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
